// File: rtl/codec_init_seq.sv
// Power-up register initialisation sequencer for an I2C-attached codec.
// Walks a fixed 11-entry table, with per-entry retry and timeout handling.
module codec_init_seq #(
    parameter int PWR_WAIT   = 256,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1023,
    parameter int MAX_RETRY  = 3
) (
    input  logic       I2C_clk,
    input  logic       reset,
    input  logic       ready,
    input  logic       error,
    input  logic       restart,
    output logic       Write,
    output logic [7:0] SubAddrL,
    output logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] progress
);

    localparam int MAX_PT   = (PWR_WAIT > TIMEOUT) ? PWR_WAIT : TIMEOUT;
    localparam int MAX_CNT  = (MAX_PT > GAP_CYCLES) ? MAX_PT : GAP_CYCLES;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);
    localparam int RTR_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_WAIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [RTR_W-1:0] RTR_MAX  = RTR_W'(MAX_RETRY);
    localparam logic [3:0]       LAST_IDX = 4'd10;

    typedef enum logic [2:0] {
        PWR, ISSUE, WAIT_ACK, WAIT_DONE, GAP, DONE, FAIL
    } state_t;

    state_t           state, state_n;
    logic [3:0]       idx, idx_n;
    logic [RTR_W-1:0] retry, retry_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             write_n;
    logic [7:0]       sub_n, data_n;
    logic             attempt_failed;

    // {SubAddrL, data} for each table index
    function automatic logic [15:0] table_entry(input logic [3:0] i);
        case (i)
            4'd0:    table_entry = 16'h0001;
            4'd1:    table_entry = 16'h1501;
            4'd2:    table_entry = 16'h0A01;
            4'd3:    table_entry = 16'h0C01;
            4'd4:    table_entry = 16'h1C21;
            4'd5:    table_entry = 16'h1E41;
            4'd6:    table_entry = 16'h1903;
            4'd7:    table_entry = 16'h2A03;
            4'd8:    table_entry = 16'h2903;
            4'd9:    table_entry = 16'hF97F;
            4'd10:   table_entry = 16'hFA01;
            default: table_entry = 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_n        = state;
        idx_n          = idx;
        retry_n        = retry;
        cnt_n          = cnt + CNT_W'(1);
        write_n        = 1'b0;
        sub_n          = SubAddrL;
        data_n         = data;
        attempt_failed = 1'b0;

        case (state)
            PWR: begin
                if (cnt == PWR_LAST) begin
                    state_n = ISSUE;
                    cnt_n   = '0;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            ISSUE: begin
                cnt_n = '0;
                if (ready) begin
                    write_n         = 1'b1;
                    {sub_n, data_n} = table_entry(idx);
                    state_n         = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!ready) begin
                    state_n = WAIT_DONE;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    attempt_failed = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (ready) begin
                    if (error) begin
                        attempt_failed = 1'b1;
                    end else begin
                        retry_n = '0;
                        cnt_n   = '0;
                        if (idx == LAST_IDX) begin
                            state_n = DONE;
                        end else begin
                            idx_n   = idx + 4'd1;
                            state_n = GAP;
                        end
                    end
                end else if (cnt == TO_LAST) begin
                    attempt_failed = 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ISSUE;
                    cnt_n   = '0;
                end
            end
            DONE, FAIL: begin
                cnt_n = '0;
                if (restart) begin
                    state_n = ISSUE;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            default: state_n = PWR;
        endcase

        // A NACK or a timeout retries the same index until the retry budget runs out
        if (attempt_failed) begin
            cnt_n = '0;
            if (retry == RTR_MAX) begin
                state_n = FAIL;
            end else begin
                retry_n = retry + RTR_W'(1);
                state_n = GAP;
            end
        end
    end

    always_ff @(posedge I2C_clk) begin
        if (!reset) begin
            state    <= PWR;
            idx      <= '0;
            retry    <= '0;
            cnt      <= '0;
            Write    <= 1'b0;
            SubAddrL <= 8'h00;
            data     <= 8'h00;
            busy     <= 1'b1;
            done     <= 1'b0;
            fail     <= 1'b0;
            progress <= 4'd0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            retry    <= retry_n;
            cnt      <= cnt_n;
            Write    <= write_n;
            SubAddrL <= sub_n;
            data     <= data_n;
            busy     <= !((state_n == DONE) || (state_n == FAIL));
            done     <= (state_n == DONE);
            fail     <= (state_n == FAIL);
            progress <= idx_n;
        end
    end

endmodule

// File: tb/tb_codec_init_seq.sv
// Directed bench for codec_init_seq: an I2C-master model acks writes and
// logs every Write pulse; each scenario task checks against fixed expectations.
module tb_codec_init_seq;

    localparam int PWR_WAIT   = 8;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 20;
    localparam int MAX_RETRY  = 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       ready   = 1'b1;
    logic       error   = 1'b0;
    logic       restart = 1'b0;
    logic       Write;
    logic [7:0] SubAddrL;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] progress;

    int vectors     = 0;
    int miscompares = 0;

    // master model controls and write log
    bit         hold_ready = 1'b0;
    int         nack_mode  = 0;      // 0 none, 1 first attempt only, 2 every attempt
    logic [7:0] nack_sub   = 8'h00;
    bit         nack_pend  = 1'b0;
    int         busy_cnt   = 0;
    int         wr_cnt     = 0;
    int         cyc        = 0;
    logic [7:0] log_sub  [0:511];
    logic [7:0] log_data [0:511];
    int         log_cyc  [0:511];

    logic [15:0] exp_tab [0:10] = '{16'h0001, 16'h1501, 16'h0A01, 16'h0C01,
                                    16'h1C21, 16'h1E41, 16'h1903, 16'h2A03,
                                    16'h2903, 16'hF97F, 16'hFA01};

    codec_init_seq #(
        .PWR_WAIT  (PWR_WAIT),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .I2C_clk (clk),
        .reset   (reset),
        .ready   (ready),
        .error   (error),
        .restart (restart),
        .Write   (Write),
        .SubAddrL(SubAddrL),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .fail    (fail),
        .progress(progress)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            ready    = 1'b1;
            error    = 1'b0;
            busy_cnt = 0;
        end else if (Write) begin
            if (wr_cnt < 512) begin
                log_sub[wr_cnt]  = SubAddrL;
                log_data[wr_cnt] = data;
                log_cyc[wr_cnt]  = cyc;
            end
            nack_pend = (nack_mode == 2 && SubAddrL == nack_sub) ||
                        (nack_mode == 1 && SubAddrL == nack_sub &&
                         (wr_cnt == 0 || log_sub[wr_cnt-1] != nack_sub));
            wr_cnt = wr_cnt + 1;
            error  = 1'b0;
            if (!hold_ready) begin
                ready    = 1'b0;
                busy_cnt = 3;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) begin
                ready = 1'b1;
                error = nack_pend;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done || fail) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        vectors++; if (Write !== 1'b0) begin miscompares++; $display("FAIL reset_write: got %b want 0", Write); end
        vectors++; if (SubAddrL !== 8'h00) begin miscompares++; $display("FAIL reset_subaddr: got %h want 00", SubAddrL); end
        vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail: got %b want 0", fail); end
        vectors++; if (progress !== 4'd0) begin miscompares++; $display("FAIL reset_progress: got %0d want 0", progress); end
        reset = 1'b1;
    endtask

    task automatic test_normal();
        int base;
        int n;
        bit ok;
        base = wr_cnt;
        n = 0;
        while (!Write && n < 100) begin
            step();
            n++;
        end
        vectors++; if (n != PWR_WAIT + 1) begin miscompares++; $display("FAIL normal_pwr_wait: got %0d cycles want %0d", n, PWR_WAIT + 1); end
        wait_end(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL normal_timeout: sequence did not end"); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL normal_done: got %b want 1", done); end
        vectors++; if (fail !== 1'b0) begin miscompares++; $display("FAIL normal_fail: got %b want 0", fail); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL normal_busy: got %b want 0", busy); end
        vectors++; if (progress !== 4'd10) begin miscompares++; $display("FAIL normal_progress: got %0d want 10", progress); end
        vectors++; if (wr_cnt - base != 11) begin miscompares++; $display("FAIL normal_writes: got %0d want 11", wr_cnt - base); end
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if ({log_sub[base+i], log_data[base+i]} !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL normal_entry%0d: got %h want %h", i, {log_sub[base+i], log_data[base+i]}, exp_tab[i]);
            end
        end
        base = wr_cnt;
        repeat (20) step();
        vectors++; if (done !== 1'b1 || wr_cnt != base) begin miscompares++; $display("FAIL done_sticky: done %b extra writes %0d want done 1, 0 writes", done, wr_cnt - base); end
    endtask

    task automatic test_restart();
        int base;
        int n;
        bit ok;
        base = wr_cnt;
        restart = 1'b1;
        step();
        vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL restart_flags: busy %b done %b want busy 1 done 0", busy, done); end
        restart = 1'b0;
        n = 1;
        while (!Write && n < 100) begin
            step();
            n++;
        end
        vectors++; if (n != 2) begin miscompares++; $display("FAIL restart_latency: got %0d cycles want 2", n); end
        n = 0;
        while (wr_cnt - base < 3 && n < 200) begin
            step();
            n++;
        end
        pulse_restart();
        wait_end(ok);
        vectors++; if (!ok || done !== 1'b1) begin miscompares++; $display("FAIL restart_done: got %b want 1", done); end
        vectors++; if (wr_cnt - base != 11) begin miscompares++; $display("FAIL restart_busy_ignored: got %0d writes want 11", wr_cnt - base); end
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if ({log_sub[base+i], log_data[base+i]} !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL restart_entry%0d: got %h want %h", i, {log_sub[base+i], log_data[base+i]}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_single_nack();
        int base;
        bit ok;
        nack_mode = 1;
        nack_sub  = 8'h0C;
        base = wr_cnt;
        pulse_restart();
        wait_end(ok);
        nack_mode = 0;
        vectors++; if (!ok || done !== 1'b1) begin miscompares++; $display("FAIL nack1_done: got %b want 1", done); end
        vectors++; if (wr_cnt - base != 12) begin miscompares++; $display("FAIL nack1_writes: got %0d want 12", wr_cnt - base); end
        vectors++; if ({log_sub[base+3], log_data[base+3]} !== 16'h0C01) begin miscompares++; $display("FAIL nack1_first: got %h want 0C01", {log_sub[base+3], log_data[base+3]}); end
        vectors++; if ({log_sub[base+4], log_data[base+4]} !== 16'h0C01) begin miscompares++; $display("FAIL nack1_retry: got %h want 0C01", {log_sub[base+4], log_data[base+4]}); end
        vectors++; if ({log_sub[base+5], log_data[base+5]} !== 16'h1C21) begin miscompares++; $display("FAIL nack1_next: got %h want 1C21", {log_sub[base+5], log_data[base+5]}); end
        // 4 cycles of handshake, GAP_CYCLES of gap, one ISSUE cycle
        vectors++; if (log_cyc[base+4] - log_cyc[base+3] != 4 + GAP_CYCLES + 1) begin miscompares++; $display("FAIL nack1_spacing: got %0d want %0d", log_cyc[base+4] - log_cyc[base+3], 4 + GAP_CYCLES + 1); end
        vectors++; if ({log_sub[base+11], log_data[base+11]} !== 16'hFA01) begin miscompares++; $display("FAIL nack1_last: got %h want FA01", {log_sub[base+11], log_data[base+11]}); end
    endtask

    task automatic test_persistent_nack();
        int base;
        int n1e;
        bit ok;
        nack_mode = 2;
        nack_sub  = 8'h1E;
        base = wr_cnt;
        pulse_restart();
        wait_end(ok);
        nack_mode = 0;
        n1e = 0;
        for (int i = base; i < wr_cnt; i++) if (log_sub[i] == 8'h1E) n1e++;
        vectors++; if (!ok || fail !== 1'b1) begin miscompares++; $display("FAIL nackp_fail: got %b want 1", fail); end
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL nackp_flags: done %b busy %b want 0 0", done, busy); end
        vectors++; if (progress !== 4'd5) begin miscompares++; $display("FAIL nackp_progress: got %0d want 5", progress); end
        vectors++; if (n1e != 4) begin miscompares++; $display("FAIL nackp_1e_writes: got %0d want 4", n1e); end
        vectors++; if (wr_cnt - base != 9) begin miscompares++; $display("FAIL nackp_writes: got %0d want 9", wr_cnt - base); end
        base = wr_cnt;
        repeat (60) step();
        vectors++; if (wr_cnt != base || fail !== 1'b1) begin miscompares++; $display("FAIL nackp_sticky: extra writes %0d fail %b want 0 and 1", wr_cnt - base, fail); end
    endtask

    task automatic test_timeout();
        int base;
        bit ok;
        hold_ready = 1'b1;
        base = wr_cnt;
        pulse_restart();
        wait_end(ok);
        hold_ready = 1'b0;
        vectors++; if (!ok || fail !== 1'b1) begin miscompares++; $display("FAIL tmo_fail: got %b want 1", fail); end
        vectors++; if (progress !== 4'd0) begin miscompares++; $display("FAIL tmo_progress: got %0d want 0", progress); end
        vectors++; if (wr_cnt - base != 4) begin miscompares++; $display("FAIL tmo_writes: got %0d want 4", wr_cnt - base); end
        vectors++; if (log_sub[base+3] !== 8'h00) begin miscompares++; $display("FAIL tmo_subaddr: got %h want 00", log_sub[base+3]); end
        vectors++; if (log_cyc[base+1] - log_cyc[base] != TIMEOUT + GAP_CYCLES + 1) begin miscompares++; $display("FAIL tmo_spacing: got %0d want %0d", log_cyc[base+1] - log_cyc[base], TIMEOUT + GAP_CYCLES + 1); end
    endtask

    task automatic test_midrun_reset();
        int base;
        int n;
        bit ok;
        base = wr_cnt;
        pulse_restart();
        n = 0;
        while (!(wr_cnt - base == 8 && !ready && !Write) && n < 500) begin
            step();
            n++;
        end
        vectors++; if (log_sub[base+7] !== 8'h2A) begin miscompares++; $display("FAIL mid_index7: got %h want 2A", log_sub[base+7]); end
        reset = 1'b0;
        step();
        vectors++; if (Write !== 1'b0 || SubAddrL !== 8'h00 || data !== 8'h00) begin miscompares++; $display("FAIL mid_reset_data: Write %b sub %h data %h want 0 00 00", Write, SubAddrL, data); end
        vectors++; if (busy !== 1'b1 || done !== 1'b0 || fail !== 1'b0 || progress !== 4'd0) begin miscompares++; $display("FAIL mid_reset_flags: busy %b done %b fail %b prog %0d want 1 0 0 0", busy, done, fail, progress); end
        step();
        reset = 1'b1;
        base = wr_cnt;
        n = 0;
        while (!Write && n < 100) begin
            step();
            n++;
        end
        vectors++; if (n != PWR_WAIT + 1) begin miscompares++; $display("FAIL mid_pwr_wait: got %0d cycles want %0d", n, PWR_WAIT + 1); end
        vectors++; if (SubAddrL !== 8'h00 || data !== 8'h01) begin miscompares++; $display("FAIL mid_first_write: got %h%h want 0001", SubAddrL, data); end
        wait_end(ok);
        vectors++; if (!ok || done !== 1'b1 || wr_cnt - base != 11) begin miscompares++; $display("FAIL mid_rerun: done %b writes %0d want 1 and 11", done, wr_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_restart();
        test_single_nack();
        test_persistent_nack();
        test_timeout();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
